// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage_pkg
// Purpose  : Shared constants for the memory-access pipeline stage.
//            - RISC-V load/store op encodings (MEM_*)
//            - TRUE/FALSE single-bit constants
//            - is_mem_op() helper: op codes 9-15 behave as MEM_NONE
// Revision : 1.0  initial release
// ============================================================================
package mem_access_stage_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Only encodings 1..8 touch memory; everything else is a pass-through.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage_if
// Purpose  : Bundles the three buses of the memory-access stage:
//            - upstream  : mem_in_* from execute, mem_out_stall back to it
//            - data bus  : dmem_req/we/addr/wdata/be out, dmem_ack/rdata in
//            - writeback : wb_valid/en/rd/data plus error pulses
//            modport slave  : the stage itself
//            modport master : the surrounding environment
// Revision : 1.0  initial release
// ============================================================================
interface mem_access_stage_if;

  logic        mem_in_valid;
  logic        mem_in_alu_busy;
  logic [31:0] mem_in_result;
  logic [31:0] mem_in_store_data;
  logic [3:0]  mem_in_op;
  logic [4:0]  mem_in_rd;
  logic        mem_in_wb_en;
  logic        mem_out_stall;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  logic        wb_valid;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_out_misaligned;
  logic        mem_out_bus_err;

  modport slave (
    input  mem_in_valid, mem_in_alu_busy, mem_in_result, mem_in_store_data,
           mem_in_op, mem_in_rd, mem_in_wb_en, dmem_ack, dmem_rdata,
    output mem_out_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
           wb_valid, wb_en, wb_rd, wb_data, mem_out_misaligned, mem_out_bus_err
  );

  modport master (
    output mem_in_valid, mem_in_alu_busy, mem_in_result, mem_in_store_data,
           mem_in_op, mem_in_rd, mem_in_wb_en, dmem_ack, dmem_rdata,
    input  mem_out_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
           wb_valid, wb_en, wb_rd, wb_data, mem_out_misaligned, mem_out_bus_err
  );

endinterface
`default_nettype wire

// File: rtl/mem_access_stage_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Purpose  : Combinational byte-lane handling for the memory-access stage.
//            Store side (from the incoming instruction):
//              i_st_op, i_st_addr_lo, i_st_data -> o_be, o_wdata,
//              o_misaligned, o_is_mem, o_is_store
//            Load side (from the latched in-flight access):
//              i_ld_op, i_ld_addr_lo, i_rdata   -> o_ld_data
// Revision : 1.0  initial release
// ============================================================================
module mem_lane_align
  import mem_access_stage_pkg::*;
(
  input  logic [3:0]  i_st_op,
  input  logic [1:0]  i_st_addr_lo,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misaligned,
  output logic        o_is_mem,
  output logic        o_is_store,
  input  logic [3:0]  i_ld_op,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_lane;

  // Loads use the same byte-enable pattern as the store of equal width.
  always_comb begin
    o_be         = 4'b0000;
    o_wdata      = i_st_data;
    o_misaligned = FALSE;
    o_is_mem     = is_mem_op(i_st_op);
    o_is_store   = FALSE;
    case (i_st_op)
      MEM_LB, MEM_LBU: begin
        o_be = 4'b0001 << i_st_addr_lo;
      end
      MEM_SB: begin
        o_be       = 4'b0001 << i_st_addr_lo;
        o_wdata    = {4{i_st_data[7:0]}};
        o_is_store = TRUE;
      end
      MEM_LH, MEM_LHU: begin
        o_be         = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_misaligned = i_st_addr_lo[0];
      end
      MEM_SH: begin
        o_be         = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata      = {2{i_st_data[15:0]}};
        o_misaligned = i_st_addr_lo[0];
        o_is_store   = TRUE;
      end
      MEM_LW: begin
        o_be         = 4'b1111;
        o_misaligned = |i_st_addr_lo;
      end
      MEM_SW: begin
        o_be         = 4'b1111;
        o_misaligned = |i_st_addr_lo;
        o_is_store   = TRUE;
      end
      default: begin
        o_be = 4'b0000;
      end
    endcase
  end

  // Bring the addressed byte/halfword down to bit 0.
  assign w_lane = i_rdata >> {i_ld_addr_lo, 3'b000};

  always_comb begin
    o_ld_data = i_rdata;
    case (i_ld_op)
      MEM_LB:  o_ld_data = {{24{w_lane[7]}}, w_lane[7:0]};
      MEM_LBU: o_ld_data = {24'd0, w_lane[7:0]};
      MEM_LH:  o_ld_data = {{16{w_lane[15]}}, w_lane[15:0]};
      MEM_LHU: o_ld_data = {16'd0, w_lane[15:0]};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : Pipeline stage after execute. Passes ALU results through to
//            writeback, or uses them as the effective address of a RISC-V
//            load/store performed over a single-outstanding req/ack bus.
// Ports    : clk, reset (async, active-high)
//            bus : mem_access_stage_if.slave (upstream, dmem, writeback)
// Params   : TIMEOUT_CYCLES - request cycles without ack before bus error
// Revision : 1.0  initial release
// ============================================================================
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
)(
  input  logic                   clk,
  input  logic                   reset,
  mem_access_stage_if.slave      bus
);

  localparam logic [0:0]  c_IDLE = 1'b0;
  localparam logic [0:0]  c_WAIT = 1'b1;
  // The counter holds the number of already-elapsed WAIT cycles, so the
  // last permitted request cycle is the one where it equals TIMEOUT-1.
  localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [0:0]  r_state;
  logic [15:0] r_count;
  logic [3:0]  r_op;
  logic [1:0]  r_off;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_we;
  logic [4:0]  r_rd;
  logic        r_wb_en;

  logic        r_wb_valid;
  logic        r_wb_en_out;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_misaligned;
  logic        r_bus_err;

  logic        w_accept;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_misaligned;
  logic        w_is_mem;
  logic        w_is_store;
  logic [31:0] w_ld_data;

  // Stall comes straight from the state flop, so there is no
  // combinational path from mem_in_* to mem_out_stall.
  assign bus.mem_out_stall = (r_state == c_WAIT);
  assign w_accept = bus.mem_in_valid & ~bus.mem_in_alu_busy & ~bus.mem_out_stall;

  mem_lane_align u_align (
    .i_st_op      (bus.mem_in_op),
    .i_st_addr_lo (bus.mem_in_result[1:0]),
    .i_st_data    (bus.mem_in_store_data),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_misaligned (w_misaligned),
    .o_is_mem     (w_is_mem),
    .o_is_store   (w_is_store),
    .i_ld_op      (r_op),
    .i_ld_addr_lo (r_off),
    .i_rdata      (bus.dmem_rdata),
    .o_ld_data    (w_ld_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= c_IDLE;
      r_count      <= '0;
      r_op         <= '0;
      r_off        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_we         <= 1'b0;
      r_rd         <= '0;
      r_wb_en      <= 1'b0;
      r_wb_valid   <= 1'b0;
      r_wb_en_out  <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_data    <= '0;
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_wb_valid   <= 1'b0;
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            if (!w_is_mem) begin
              r_wb_valid  <= 1'b1;
              r_wb_en_out <= bus.mem_in_wb_en;
              r_wb_rd     <= bus.mem_in_rd;
              r_wb_data   <= bus.mem_in_result;
            end else if (w_misaligned) begin
              // Squashed: never reaches the bus, never writes rd.
              r_wb_valid   <= 1'b1;
              r_wb_en_out  <= 1'b0;
              r_wb_rd      <= bus.mem_in_rd;
              r_wb_data    <= '0;
              r_misaligned <= 1'b1;
            end else begin
              r_op    <= bus.mem_in_op;
              r_off   <= bus.mem_in_result[1:0];
              r_addr  <= {bus.mem_in_result[31:2], 2'b00};
              r_wdata <= w_wdata;
              r_be    <= w_be;
              r_we    <= w_is_store;
              r_rd    <= bus.mem_in_rd;
              r_wb_en <= bus.mem_in_wb_en;
              r_count <= '0;
              r_state <= c_WAIT;
            end
          end
        end
        c_WAIT: begin
          // Ack is tested first so an ack on the final cycle beats timeout.
          if (bus.dmem_ack) begin
            r_state    <= c_IDLE;
            r_wb_valid <= 1'b1;
            r_wb_rd    <= r_rd;
            if (r_we) begin
              r_wb_en_out <= 1'b0;
              r_wb_data   <= '0;
            end else begin
              r_wb_en_out <= r_wb_en;
              r_wb_data   <= w_ld_data;
            end
          end else if (r_count == c_TIMEOUT_LAST) begin
            r_state     <= c_IDLE;
            r_wb_valid  <= 1'b1;
            r_wb_en_out <= 1'b0;
            r_wb_rd     <= r_rd;
            r_wb_data   <= '0;
            r_bus_err   <= 1'b1;
          end else begin
            r_count <= r_count + 16'd1;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.dmem_req           = (r_state == c_WAIT);
  assign bus.dmem_we            = r_we;
  assign bus.dmem_addr          = r_addr;
  assign bus.dmem_wdata         = r_wdata;
  assign bus.dmem_be            = r_be;
  assign bus.wb_valid           = r_wb_valid;
  assign bus.wb_en              = r_wb_en_out;
  assign bus.wb_rd              = r_wb_rd;
  assign bus.wb_data            = r_wb_data;
  assign bus.mem_out_misaligned = r_misaligned;
  assign bus.mem_out_bus_err    = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Purpose  : Scoreboard bench for mem_access_stage (TIMEOUT_CYCLES = 4).
//            Directed stimulus pushes expected writeback records and bus
//            requests into queues; a memory responder and a writeback
//            monitor pop and compare them independently.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  typedef struct {
    logic        en;
    logic [4:0]  rd;
    logic        chk_rd;
    logic [31:0] data;
    logic        chk_data;
    logic        mis;
    logic        err;
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic [31:0] rdata;
    int          delay;   // request cycle carrying ack; 0 = never ack
  } bus_exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   fails  = 0;
  int   wb_seen = 0;
  logic late_ack = 1'b0;

  wb_exp_t  wb_q[$];
  bus_exp_t bus_q[$];

  mem_access_stage_if bus_if ();

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic exp_wb(input logic en, input logic [4:0] rd, input logic chk_rd,
                        input logic [31:0] data, input logic chk_data,
                        input logic mis, input logic err);
    wb_exp_t e;
    e.en = en; e.rd = rd; e.chk_rd = chk_rd; e.data = data;
    e.chk_data = chk_data; e.mis = mis; e.err = err;
    wb_q.push_back(e);
  endtask

  task automatic exp_bus(input logic [31:0] addr, input logic [3:0] be, input logic we,
                         input logic [31:0] wdata, input logic chk_wdata,
                         input logic [31:0] rdata, input int delay);
    bus_exp_t e;
    e.addr = addr; e.be = be; e.we = we; e.wdata = wdata;
    e.chk_wdata = chk_wdata; e.rdata = rdata; e.delay = delay;
    bus_q.push_back(e);
  endtask

  // Present one instruction and hold it until the stage accepts it.
  task automatic send(input logic [3:0] op, input logic [31:0] res, input logic [31:0] sd,
                      input logic [4:0] rd, input logic wben);
    int guard = 0;
    @(negedge clk);
    bus_if.mem_in_valid      = 1'b1;
    bus_if.mem_in_alu_busy   = 1'b0;
    bus_if.mem_in_op         = op;
    bus_if.mem_in_result     = res;
    bus_if.mem_in_store_data = sd;
    bus_if.mem_in_rd         = rd;
    bus_if.mem_in_wb_en      = wben;
    while (bus_if.mem_out_stall && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 bus_if.mem_in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((wb_q.size() != 0 || bus_if.dmem_req) && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) check("drain_timeout", 32'd1, 32'd0);
  endtask

  // Writeback monitor.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      if (bus_if.wb_valid === 1'b1) begin
        wb_exp_t e;
        wb_seen++;
        if (wb_q.size() == 0) begin
          check("unexpected_wb_valid", 32'd1, 32'd0);
        end else begin
          e = wb_q.pop_front();
          check("wb_en", {31'd0, bus_if.wb_en}, {31'd0, e.en});
          if (e.chk_rd) check("wb_rd", {27'd0, bus_if.wb_rd}, {27'd0, e.rd});
          if (e.chk_data) check("wb_data", bus_if.wb_data, e.data);
          check("misaligned", {31'd0, bus_if.mem_out_misaligned}, {31'd0, e.mis});
          check("bus_err", {31'd0, bus_if.mem_out_bus_err}, {31'd0, e.err});
        end
      end else if (bus_if.mem_out_misaligned !== 1'b0 || bus_if.mem_out_bus_err !== 1'b0) begin
        check("error_pulse_without_wb", 32'd1, 32'd0);
      end
    end
  end

  // Memory responder: checks each request and acks after its delay.
  initial begin : responder
    bus_exp_t cur;
    logic in_req = 1'b0;
    logic ack_m  = 1'b0;
    int   cyc    = 0;
    cur.delay = 1; cur.rdata = '0;
    bus_if.dmem_ack   = 1'b0;
    bus_if.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      ack_m = 1'b0;
      if (reset === 1'b1) begin
        in_req = 1'b0;
      end else if (bus_if.dmem_req === 1'b1) begin
        if (!in_req) begin
          in_req = 1'b1;
          cyc    = 0;
          if (bus_q.size() == 0) begin
            check("unexpected_dmem_req", 32'd1, 32'd0);
            cur.delay = 1; cur.rdata = '0;
          end else begin
            cur = bus_q.pop_front();
            check("dmem_addr", bus_if.dmem_addr, cur.addr);
            check("dmem_be", {28'd0, bus_if.dmem_be}, {28'd0, cur.be});
            check("dmem_we", {31'd0, bus_if.dmem_we}, {31'd0, cur.we});
            if (cur.chk_wdata) check("dmem_wdata", bus_if.dmem_wdata, cur.wdata);
          end
        end
        cyc++;
        if (cur.delay != 0 && cyc == cur.delay) begin
          ack_m = 1'b1;
          bus_if.dmem_rdata = cur.rdata;
        end
      end else if (in_req) begin
        in_req = 1'b0;
        check("req_cycles", cyc, (cur.delay != 0) ? cur.delay : 4);
      end
      bus_if.dmem_ack = ack_m | late_ack;
    end
  end

  initial begin : stimulus
    int wb_before;
    reset = 1'b1;
    bus_if.mem_in_valid      = 1'b0;
    bus_if.mem_in_alu_busy   = 1'b0;
    bus_if.mem_in_op         = 4'd0;
    bus_if.mem_in_result     = '0;
    bus_if.mem_in_store_data = '0;
    bus_if.mem_in_rd         = '0;
    bus_if.mem_in_wb_en      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dmem_req",  {31'd0, bus_if.dmem_req}, 32'd0);
    check("rst_wb_valid",  {31'd0, bus_if.wb_valid}, 32'd0);
    check("rst_stall",     {31'd0, bus_if.mem_out_stall}, 32'd0);
    check("rst_err_pulse", {30'd0, bus_if.mem_out_misaligned, bus_if.mem_out_bus_err}, 32'd0);
    check("rst_dmem_be",   {28'd0, bus_if.dmem_be}, 32'd0);
    check("rst_dmem_addr", bus_if.dmem_addr, 32'd0);
    reset = 1'b0;

    // Pass-through
    exp_wb(1'b1, 5'd5, 1'b1, 32'h0000_1234, 1'b1, 1'b0, 1'b0);
    send(MEM_NONE, 32'h0000_1234, 32'd0, 5'd5, 1'b1);
    @(negedge clk);
    check("none_stall", {31'd0, bus_if.mem_out_stall}, 32'd0);

    // Back-to-back pass-through, including an unused op code
    exp_wb(1'b0, 5'd9,  1'b1, 32'hAAAA_0001, 1'b1, 1'b0, 1'b0);
    exp_wb(1'b1, 5'd10, 1'b1, 32'h0000_0055, 1'b1, 1'b0, 1'b0);
    send(MEM_NONE, 32'hAAAA_0001, 32'd0, 5'd9, 1'b0);
    send(4'd12,    32'h0000_0055, 32'd0, 5'd10, 1'b1);

    // LB sign-extended, ack in third request cycle
    exp_bus(32'h100, 4'b1000, 1'b0, 32'd0, 1'b0, 32'h80FF_0000, 3);
    exp_wb(1'b1, 5'd7, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0);
    send(MEM_LB, 32'h103, 32'd0, 5'd7, 1'b1);

    // SH upper half, ack first cycle
    exp_bus(32'h200, 4'b1100, 1'b1, 32'hBEEF_BEEF, 1'b1, 32'd0, 1);
    exp_wb(1'b0, 5'd3, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    send(MEM_SH, 32'h202, 32'hDEAD_BEEF, 5'd3, 1'b1);

    // Misaligned accesses: no request
    exp_wb(1'b0, 5'd4, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    send(MEM_LW, 32'h301, 32'd0, 5'd4, 1'b1);
    exp_wb(1'b0, 5'd4, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    send(MEM_LH, 32'h101, 32'd0, 5'd4, 1'b1);
    exp_wb(1'b0, 5'd4, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    send(MEM_SH, 32'h003, 32'h1111_2222, 5'd4, 1'b0);

    // Other widths and extensions
    exp_bus(32'h100, 4'b0010, 1'b0, 32'd0, 1'b0, 32'h0000_A500, 2);
    exp_wb(1'b1, 5'd8, 1'b1, 32'h0000_00A5, 1'b1, 1'b0, 1'b0);
    send(MEM_LBU, 32'h101, 32'd0, 5'd8, 1'b1);
    exp_bus(32'h100, 4'b1100, 1'b0, 32'd0, 1'b0, 32'h8001_1234, 1);
    exp_wb(1'b1, 5'd11, 1'b1, 32'hFFFF_8001, 1'b1, 1'b0, 1'b0);
    send(MEM_LH, 32'h102, 32'd0, 5'd11, 1'b1);
    exp_bus(32'h100, 4'b1100, 1'b0, 32'd0, 1'b0, 32'h8001_0000, 1);
    exp_wb(1'b1, 5'd12, 1'b1, 32'h0000_8001, 1'b1, 1'b0, 1'b0);
    send(MEM_LHU, 32'h102, 32'd0, 5'd12, 1'b1);
    exp_bus(32'h000, 4'b0010, 1'b1, 32'h7878_7878, 1'b1, 32'd0, 1);
    exp_wb(1'b0, 5'd1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    send(MEM_SB, 32'h001, 32'h1234_5678, 5'd1, 1'b0);
    exp_bus(32'h010, 4'b1111, 1'b1, 32'hCAFE_F00D, 1'b1, 32'd0, 2);
    exp_wb(1'b0, 5'd2, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    send(MEM_SW, 32'h010, 32'hCAFE_F00D, 5'd2, 1'b1);
    exp_bus(32'h020, 4'b1111, 1'b0, 32'd0, 1'b0, 32'h1122_3344, 1);
    exp_wb(1'b0, 5'd13, 1'b1, 32'h1122_3344, 1'b1, 1'b0, 1'b0);
    send(MEM_LW, 32'h020, 32'd0, 5'd13, 1'b0);

    // Ack on the last permitted cycle beats the timeout
    exp_bus(32'h040, 4'b1111, 1'b0, 32'd0, 1'b0, 32'hA5A5_A5A5, 4);
    exp_wb(1'b1, 5'd14, 1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b0);
    send(MEM_LW, 32'h040, 32'd0, 5'd14, 1'b1);
    // Pass-through accepted in the cycle right after completion
    exp_wb(1'b1, 5'd15, 1'b1, 32'h0000_0777, 1'b1, 1'b0, 1'b0);
    send(MEM_NONE, 32'h0000_0777, 32'd0, 5'd15, 1'b1);
    wait_drain();

    // Timeout, then a late ack in IDLE must be ignored
    exp_bus(32'h400, 4'b1111, 1'b0, 32'd0, 1'b0, 32'd0, 0);
    exp_wb(1'b0, 5'd6, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    send(MEM_LW, 32'h400, 32'd0, 5'd6, 1'b1);
    wait_drain();
    wb_before = wb_seen;
    late_ack = 1'b1;
    repeat (3) @(negedge clk);
    late_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("late_ack_ignored", wb_seen, wb_before);
    check("late_ack_no_req", {31'd0, bus_if.dmem_req}, 32'd0);

    // ALU busy blocks acceptance
    wb_before = wb_seen;
    @(negedge clk);
    bus_if.mem_in_valid    = 1'b1;
    bus_if.mem_in_alu_busy = 1'b1;
    bus_if.mem_in_op       = MEM_LW;
    bus_if.mem_in_result   = 32'h600;
    repeat (10) @(negedge clk);
    bus_if.mem_in_valid    = 1'b0;
    bus_if.mem_in_alu_busy = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_no_accept", wb_seen, wb_before);

    // Reset in the middle of an access
    exp_bus(32'h500, 4'b1111, 1'b0, 32'd0, 1'b0, 32'd0, 0);
    send(MEM_LW, 32'h500, 32'd0, 5'd20, 1'b1);
    @(negedge clk);
    check("wait_req_high", {31'd0, bus_if.dmem_req}, 32'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("reset_drops_req", {31'd0, bus_if.dmem_req}, 32'd0);
    check("reset_drops_stall", {31'd0, bus_if.mem_out_stall}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wb_before = wb_seen;
    repeat (4) @(negedge clk);
    check("reset_no_wb", wb_seen, wb_before);

    check("wb_queue_empty", wb_q.size(), 32'd0);
    check("bus_queue_empty", bus_q.size(), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline stage directly downstream of the execute (ALU) stage. Takes the ALU result as either a writeback value or an effective address and performs RISC-V loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) over a single-outstanding req/ack data-memory bus. Produces the writeback record for the register file. Holds the execute stage via a stall output while a memory access is in flight.

## Interface
- TIMEOUT_CYCLES, 255: cycles in WAIT without `dmem_ack` before a bus error is raised (1..65535)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- mem_in_valid  in  1  execute stage presents an instruction
- mem_in_alu_busy  in  1  execute stage still computing (multicycle divide); inputs not valid
- mem_in_result  in  32  ALU result: writeback value, or effective address for memory ops
- mem_in_store_data  in  32  rs2 value for stores
- mem_in_op  in  4  MEM_NONE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8; 9-15 treated as MEM_NONE
- mem_in_rd  in  5  destination register
- mem_in_wb_en  in  1  instruction writes rd
- mem_out_stall  out  1  stage cannot accept; upstream holds
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  completion; meaningful only while `dmem_req`=1
- dmem_rdata  in  32  read word, valid with `dmem_ack`
- wb_valid  out  1  writeback record valid (one-cycle pulse per instruction)
- wb_en  out  1  write rd
- wb_rd  out  5  destination
- wb_data  out  32  write value
- mem_out_misaligned  out  1  one-cycle pulse, misaligned access squashed
- mem_out_bus_err  out  1  one-cycle pulse, access timed out

## Operation
- Accept = `mem_in_valid & !mem_in_alu_busy & !mem_out_stall`. Only accepted instructions change state.
- FSM states: IDLE, WAIT.
- IDLE, accept of MEM_NONE: next cycle wb_valid=1, wb_data=mem_in_result, wb_en=mem_in_wb_en, wb_rd=mem_in_rd. Stay IDLE.
- IDLE, accept of a memory op with a misaligned address (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0): no bus request. Next cycle wb_valid=1, wb_en=0, mem_out_misaligned=1. Stay IDLE.
- IDLE, accept of an aligned memory op: latch op, address, rd, wb_en and store data. Go to WAIT. Next cycle dmem_req=1 with dmem_we/addr/be/wdata driven from latches; these hold stable until ack or timeout.
- Stores: SB be=1<<addr[1:0], wdata={4{d[7:0]}}. SH be=addr[1]?4'b1100:4'b0011, wdata={2{d[15:0]}}. SW be=4'b1111, wdata=d. Loads drive be per the same rule and we=0.
- Loads: lane = dmem_rdata >> (8*addr[1:0]). LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW uses the full word.
- WAIT, dmem_ack=1: drop req at the clock edge and return to IDLE. Next cycle wb_valid=1. Load: wb_data=extracted value, wb_en=latched wb_en. Store: wb_en=0, wb_data=0.
- WAIT, timeout counter reaches TIMEOUT_CYCLES with no ack: drop req, return to IDLE. Next cycle wb_valid=1, wb_en=0, mem_out_bus_err=1.
- Ack arriving while dmem_req=0 (IDLE) is ignored.
- Timeout counter: 16 bits, cleared on entry to WAIT, increments each WAIT cycle without ack.

## Timing
- Reset (async): state IDLE, counter 0. All outputs 0, including dmem_req, wb_valid and the error pulses. Reset during WAIT drops dmem_req immediately and loses the in-flight instruction.
- mem_out_stall = (state==WAIT); registered, no combinational path from mem_in_*.
- MEM_NONE/misaligned latency: 1 cycle, accept to wb_valid. Back-to-back acceptance every cycle.
- Memory op: accept at edge E0, dmem_req high from E0. Ack sampled at edge Ek clears req. wb_valid is high in the cycle after Ek, and a new instruction may be accepted in that same cycle.
- Minimum memory op (ack in first request cycle): 2 cycles accept to wb_valid, one stall cycle.
- Ack and timeout in the same cycle: ack wins, no bus error.
- wb_* outputs are registered. wb_valid=0 in every cycle without a completion; wb_data/rd/en are don't-care when wb_valid=0.

## Structure
- Shared package/include RISCV_constants: MEM_* op encodings, TRUE/FALSE.
- Sub-module `mem_lane_align` (combinational): the store be/wdata generator and the load extract/extend, plus the misalignment flag. Instantiated once.
- Top module holds the FSM, latches, timeout counter and writeback registers.

## Test plan
- MEM_NONE, result=0x0000_1234, rd=5, wb_en=1 → next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, stall never high.
- LB addr=0x103, memory word 0x80FF_0000, ack after 3 cycles → dmem_addr=0x100, be=4'b1000, req held 3 cycles; then wb_data=0xFFFF_FF80.
- SH addr=0x202, data=0xDEAD_BEEF, ack first cycle → be=4'b1100, wdata=0xBEEF_BEEF, we=1; wb_valid with wb_en=0.
- LW addr=0x301 → no dmem_req, next cycle mem_out_misaligned=1, wb_en=0.
- TIMEOUT_CYCLES=4, LW with no ack → req high 4 cycles, then bus_err pulse, wb_en=0. A late ack afterwards is ignored.
- mem_in_alu_busy=1 for 10 cycles with valid=1 → nothing accepted; reset asserted mid-WAIT → dmem_req=0 immediately, no wb_valid.
